// File: rtl/hazard_redirect_ctrl.sv
// EX/ID hazard and redirect control: resolves branch/jump redirects in EX, detects load-use
// stalls against the ID consumer, tracks the post-redirect shadow and keeps event counters.
module hazard_redirect_ctrl #(
    parameter int unsigned SHADOW_CYCLES = 1,
    parameter int unsigned STALL_MAX     = 1,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_valid,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_use_rs1,
    input  logic             ID_use_rs2,
    input  logic             EX_valid,
    input  logic [4:0]       EX_rd,
    input  logic             EX_MemRead,
    input  logic             EX_branch,
    input  logic             EX_br_taken,
    input  logic             EX_jump,
    input  logic             cnt_clr,
    output logic [1:0]       EX_PCSel,
    output logic             stall,
    output logic             in_shadow,
    output logic [CNT_W-1:0] cnt_redirect,
    output logic [CNT_W-1:0] cnt_stall,
    output logic             stall_err
);

    localparam logic [1:0] ShadowInit = 2'(SHADOW_CYCLES);
    localparam logic [3:0] StallMaxW  = 4'(STALL_MAX);
    localparam logic [1:0] SelSeq     = 2'b00;
    localparam logic [1:0] SelBranch  = 2'b01;
    localparam logic [1:0] SelJump    = 2'b10;

    typedef enum logic {StIdle, StShadow} shadow_state_e;

    shadow_state_e    state_q;
    logic [1:0]       shadow_cnt_q;
    logic             in_shadow_q;
    logic [3:0]       stall_run_q;
    logic [CNT_W-1:0] cnt_redirect_q;
    logic [CNT_W-1:0] cnt_stall_q;
    logic             stall_err_q;

    logic ex_live;
    logic id_live;
    logic rs1_match;
    logic rs2_match;
    logic hz;
    logic redirect;

    always_comb begin
        ex_live   = EX_valid & ~in_shadow_q;
        id_live   = ID_valid & ~in_shadow_q;
        EX_PCSel  = SelSeq;
        if (ex_live && EX_jump) begin
            EX_PCSel = SelJump;
        end else if (ex_live && EX_branch && EX_br_taken) begin
            EX_PCSel = SelBranch;
        end
        redirect  = (EX_PCSel != SelSeq);
        rs1_match = ID_use_rs1 & (ID_rs1 == EX_rd);
        rs2_match = ID_use_rs2 & (ID_rs2 == EX_rd);
        hz        = ex_live & EX_MemRead & (EX_rd != 5'd0) & id_live & (rs1_match | rs2_match);
        // A redirect flushes the consumer anyway, so it suppresses the stall.
        stall     = hz & ~redirect;
    end

    // Shadow FSM: while counting down, EX/ID contents are wrong-path bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            shadow_cnt_q <= 2'd0;
            in_shadow_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (redirect) begin
                        state_q      <= StShadow;
                        shadow_cnt_q <= ShadowInit;
                        in_shadow_q  <= 1'b1;
                    end
                end
                StShadow: begin
                    shadow_cnt_q <= shadow_cnt_q - 2'd1;
                    if (shadow_cnt_q == 2'd1) begin
                        state_q     <= StIdle;
                        in_shadow_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_run_q    <= 4'd0;
            cnt_redirect_q <= '0;
            cnt_stall_q    <= '0;
            stall_err_q    <= 1'b0;
        end else begin
            if (!stall) begin
                stall_run_q <= 4'd0;
            end else if (stall_run_q != 4'd15) begin
                stall_run_q <= stall_run_q + 4'd1;
            end

            if (cnt_clr) begin
                cnt_redirect_q <= '0;
                cnt_stall_q    <= '0;
                stall_err_q    <= 1'b0;
            end else begin
                if (redirect) begin
                    cnt_redirect_q <= cnt_redirect_q + CNT_W'(1);
                end
                if (stall) begin
                    cnt_stall_q <= cnt_stall_q + CNT_W'(1);
                end
                // Run about to exceed the limit on this edge.
                if (stall && (stall_run_q >= StallMaxW)) begin
                    stall_err_q <= 1'b1;
                end
            end
        end
    end

    assign in_shadow    = in_shadow_q;
    assign cnt_redirect = cnt_redirect_q;
    assign cnt_stall    = cnt_stall_q;
    assign stall_err    = stall_err_q;

endmodule

// File: tb/tb_hazard_redirect_ctrl.sv
// Directed bench for hazard_redirect_ctrl with default parameters (SHADOW_CYCLES=1, STALL_MAX=1).
module tb_hazard_redirect_ctrl;

    logic        clk;
    logic        rst;
    logic        ID_valid;
    logic [4:0]  ID_rs1;
    logic [4:0]  ID_rs2;
    logic        ID_use_rs1;
    logic        ID_use_rs2;
    logic        EX_valid;
    logic [4:0]  EX_rd;
    logic        EX_MemRead;
    logic        EX_branch;
    logic        EX_br_taken;
    logic        EX_jump;
    logic        cnt_clr;
    logic [1:0]  EX_PCSel;
    logic        stall;
    logic        in_shadow;
    logic [31:0] cnt_redirect;
    logic [31:0] cnt_stall;
    logic        stall_err;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_redirect_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .ID_valid     (ID_valid),
        .ID_rs1       (ID_rs1),
        .ID_rs2       (ID_rs2),
        .ID_use_rs1   (ID_use_rs1),
        .ID_use_rs2   (ID_use_rs2),
        .EX_valid     (EX_valid),
        .EX_rd        (EX_rd),
        .EX_MemRead   (EX_MemRead),
        .EX_branch    (EX_branch),
        .EX_br_taken  (EX_br_taken),
        .EX_jump      (EX_jump),
        .cnt_clr      (cnt_clr),
        .EX_PCSel     (EX_PCSel),
        .stall        (stall),
        .in_shadow    (in_shadow),
        .cnt_redirect (cnt_redirect),
        .cnt_stall    (cnt_stall),
        .stall_err    (stall_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        ID_valid = 0; ID_rs1 = 0; ID_rs2 = 0; ID_use_rs1 = 0; ID_use_rs2 = 0;
        EX_valid = 0; EX_rd = 0; EX_MemRead = 0; EX_branch = 0; EX_br_taken = 0;
        EX_jump = 0; cnt_clr = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle cycles to leave any shadow, then one clear cycle.
    task automatic clear_all();
        idle_inputs();
        tick();
        tick();
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        n_checks++;
        if (in_shadow !== 1'b0) begin n_fail++; $display("FAIL reset_in_shadow: got %b want 0", in_shadow); end
        n_checks++;
        if (cnt_redirect !== 32'd0 || cnt_stall !== 32'd0) begin
            n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", cnt_redirect, cnt_stall);
        end
        n_checks++;
        if (stall_err !== 1'b0 || EX_PCSel !== 2'b00 || stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: got err=%b sel=%b stall=%b want 0/00/0", stall_err, EX_PCSel, stall);
        end
        rst = 0;
        tick();
    endtask

    task automatic test_load_use();
        clear_all();
        EX_valid = 1; EX_MemRead = 1; EX_rd = 5;
        ID_valid = 1; ID_use_rs2 = 1; ID_rs2 = 5;
        #1;
        n_checks++;
        if (stall !== 1'b1 || EX_PCSel !== 2'b00) begin
            n_fail++; $display("FAIL load_use_active: got stall=%b sel=%b want 1/00", stall, EX_PCSel);
        end
        tick();
        EX_valid = 0;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL load_use_release: got %b want 0", stall); end
        n_checks++;
        if (cnt_stall !== 32'd1) begin n_fail++; $display("FAIL load_use_cnt: got %0d want 1", cnt_stall); end
        n_checks++;
        if (stall_err !== 1'b0 || cnt_redirect !== 32'd0) begin
            n_fail++; $display("FAIL load_use_err: got err=%b redir=%0d want 0/0", stall_err, cnt_redirect);
        end
        tick();
    endtask

    task automatic test_branch_over_hazard();
        clear_all();
        EX_valid = 1; EX_branch = 1; EX_br_taken = 1; EX_MemRead = 1; EX_rd = 3;
        ID_valid = 1; ID_rs1 = 3; ID_use_rs1 = 1;
        #1;
        n_checks++;
        if (EX_PCSel !== 2'b01 || stall !== 1'b0) begin
            n_fail++; $display("FAIL branch_hazard: got sel=%b stall=%b want 01/0", EX_PCSel, stall);
        end
        tick();
        idle_inputs();
        n_checks++;
        if (cnt_redirect !== 32'd1 || cnt_stall !== 32'd0 || in_shadow !== 1'b1) begin
            n_fail++; $display("FAIL branch_counts: got redir=%0d stall=%0d shadow=%b want 1/0/1",
                               cnt_redirect, cnt_stall, in_shadow);
        end
        tick();
    endtask

    task automatic test_shadow();
        clear_all();
        EX_valid = 1; EX_jump = 1;
        #1;
        n_checks++;
        if (EX_PCSel !== 2'b10 || in_shadow !== 1'b0) begin
            n_fail++; $display("FAIL shadow_first: got sel=%b shadow=%b want 10/0", EX_PCSel, in_shadow);
        end
        tick();
        // Wrong-path load-use pair inside the shadow must not stall.
        EX_MemRead = 1; EX_rd = 9; ID_valid = 1; ID_rs1 = 9; ID_use_rs1 = 1;
        #1;
        n_checks++;
        if (EX_PCSel !== 2'b00 || in_shadow !== 1'b1 || stall !== 1'b0) begin
            n_fail++; $display("FAIL shadow_second: got sel=%b shadow=%b stall=%b want 00/1/0",
                               EX_PCSel, in_shadow, stall);
        end
        idle_inputs();
        tick();
        n_checks++;
        if (in_shadow !== 1'b0 || cnt_redirect !== 32'd1 || cnt_stall !== 32'd0) begin
            n_fail++; $display("FAIL shadow_exit: got shadow=%b redir=%0d stall=%0d want 0/1/0",
                               in_shadow, cnt_redirect, cnt_stall);
        end
    endtask

    task automatic test_x0_unused();
        clear_all();
        EX_valid = 1; EX_MemRead = 1; EX_rd = 0;
        ID_valid = 1; ID_rs1 = 0; ID_use_rs1 = 1;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL x0_no_stall: got %b want 0", stall); end
        EX_rd = 7; ID_rs1 = 2; ID_rs2 = 7; ID_use_rs2 = 0;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL unused_rs2: got %b want 0", stall); end
        ID_use_rs2 = 1;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL used_rs2: got %b want 1", stall); end
        ID_use_rs2 = 0;
        tick();
        n_checks++;
        if (cnt_stall !== 32'd0) begin n_fail++; $display("FAIL x0_cnt: got %0d want 0", cnt_stall); end
        idle_inputs();
        tick();
    endtask

    task automatic test_runaway();
        clear_all();
        EX_valid = 1; EX_MemRead = 1; EX_rd = 12;
        ID_valid = 1; ID_rs1 = 12; ID_use_rs1 = 1;
        tick();
        n_checks++;
        if (cnt_stall !== 32'd1 || stall_err !== 1'b0) begin
            n_fail++; $display("FAIL runaway_edge1: got cnt=%0d err=%b want 1/0", cnt_stall, stall_err);
        end
        tick();
        n_checks++;
        if (cnt_stall !== 32'd2 || stall_err !== 1'b1) begin
            n_fail++; $display("FAIL runaway_edge2: got cnt=%0d err=%b want 2/1", cnt_stall, stall_err);
        end
        tick();
        n_checks++;
        if (cnt_stall !== 32'd3 || stall_err !== 1'b1) begin
            n_fail++; $display("FAIL runaway_edge3: got cnt=%0d err=%b want 3/1", cnt_stall, stall_err);
        end
        // Clear while the hazard is still present: clear beats increment and error set.
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
        n_checks++;
        if (cnt_stall !== 32'd0 || cnt_redirect !== 32'd0 || stall_err !== 1'b0) begin
            n_fail++; $display("FAIL runaway_clear: got cnt=%0d redir=%0d err=%b want 0/0/0",
                               cnt_stall, cnt_redirect, stall_err);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_async_reset();
        clear_all();
        EX_valid = 1; EX_jump = 1;
        tick();
        n_checks++;
        if (in_shadow !== 1'b1 || cnt_redirect !== 32'd1) begin
            n_fail++; $display("FAIL areset_setup: got shadow=%b redir=%0d want 1/1", in_shadow, cnt_redirect);
        end
        #2;
        rst = 1;
        #1;
        n_checks++;
        if (in_shadow !== 1'b0 || cnt_redirect !== 32'd0 || cnt_stall !== 32'd0) begin
            n_fail++; $display("FAIL areset_immediate: got shadow=%b redir=%0d stall=%0d want 0/0/0",
                               in_shadow, cnt_redirect, cnt_stall);
        end
        tick();
        #1;
        rst = 0;
        #1;
        n_checks++;
        if (EX_PCSel !== 2'b10) begin n_fail++; $display("FAIL areset_redirect: got %b want 10", EX_PCSel); end
        tick();
        n_checks++;
        if (cnt_redirect !== 32'd1 || in_shadow !== 1'b1) begin
            n_fail++; $display("FAIL areset_post: got redir=%0d shadow=%b want 1/1", cnt_redirect, in_shadow);
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_load_use();
        test_branch_over_hazard();
        test_shadow();
        test_x0_unused();
        test_runaway();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
